// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: memory read channel (req/resp) and downstream instruction
// channel of the fetch unit. master = fetch unit, slave = memory + decode.
interface ifu_prefetch_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [7:0]      req_size;
  logic            resp_valid;
  logic [DW-1:0]   resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;

  modport master (
    output req_valid, req_addr, req_size,
    input  req_ready,
    input  resp_valid, resp_data,
    output out_valid, out_pc, out_inst,
    input  out_ready
  );

  modport slave (
    input  req_valid, req_addr, req_size,
    output req_ready,
    output resp_valid, resp_data,
    input  out_valid, out_pc, out_inst,
    output out_ready
  );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential 4-byte instruction fetch into a DEPTH-entry
// prefetch FIFO, one outstanding read, redirect flushes and restarts fetch.
// Optional perf counters enabled by defining IFU_PREFETCH_PERF_EN.
module ifu_prefetch #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     AW       = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     DW       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  redirect_done,
  ifu_prefetch_if.master        bus,
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_drop_cnt
);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [AW-1:0]   req_addr_q;
  logic            stale;
  logic            redir_pend;
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            empty;
  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  logic            issue;
  logic [31:0]     resp_inst;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Pick the 32-bit instruction out of the returned beat.
  if (DW == 64) begin : g_sel64
    assign resp_inst = fetch_pc[2] ? bus.resp_data[63:32] : bus.resp_data[31:0];
  end else begin : g_sel32
    assign resp_inst = bus.resp_data[31:0];
  end

  // Handshake qualifiers, FIFO status and next-state selection.
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    accept = (state == S_REQ) && bus.req_ready;
    push   = (state == S_WAIT) && bus.resp_valid && !redirect_valid;
    pop    = !empty && bus.out_ready && !redirect_valid;
    state_nx = state;
    unique case (state)
      S_IDLE: if (!redirect_valid && !full) state_nx = S_REQ;
      // A request that was pending when a redirect hit carries the old PC,
      // so its response must be thrown away.
      S_REQ:  if (accept) state_nx = (redirect_valid || stale) ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (bus.resp_valid)      state_nx = S_IDLE;
        else if (redirect_valid) state_nx = S_DROP;
      end
      // The awaited response retires the drop even if another redirect
      // lands in the same cycle; that redirect only moves fetch_pc.
      S_DROP: if (bus.resp_valid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    issue = (state == S_IDLE) && (state_nx == S_REQ);
  end

  // FSM, fetch PC, held request address and redirect bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      req_addr_q <= '0;
      stale      <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (redirect_valid)  fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (push)       fetch_pc <= fetch_pc + XLEN'(4);
      if (issue)           req_addr_q <= fetch_pc[AW-1:0];
      if (accept)          stale <= 1'b0;
      else if (state == S_REQ && redirect_valid) stale <= 1'b1;
      if (redirect_valid)     redir_pend <= 1'b1;
      else if (redirect_done) redir_pend <= 1'b0;
    end
  end

  // Prefetch FIFO storage and pointers; redirect empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr[PW-1:0]]   <= fetch_pc;
        inst_mem[wr_ptr[PW-1:0]] <= resp_inst;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign redirect_done = accept && redir_pend && !stale && !redirect_valid;
  assign bus.req_valid = (state == S_REQ);
  assign bus.req_addr  = req_addr_q;
  assign bus.req_size  = 8'b0000_1111;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = pc_mem[rd_ptr[PW-1:0]];
  assign bus.out_inst  = inst_mem[rd_ptr[PW-1:0]];

`ifdef IFU_PREFETCH_PERF_EN
  logic drop;
  assign drop = bus.resp_valid &&
                ((state == S_DROP) || (state == S_WAIT && redirect_valid));

  // Fetched / discarded response counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (drop) perf_drop_cnt  <= perf_drop_cnt + 64'd1;
    end
  end
`else
  assign perf_fetch_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif
endmodule
